// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the LED blink scheduler: channel modes, command FSM
// states and the burst remaining-counter width.
package led_ctrl_pkg;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  localparam int REM_W = 5;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_TICK = 1'b1
  } cmd_state_t;

  // A burst of N high phases spans 2N-1 further ticks after the initial rise.
  function automatic logic [REM_W-1:0] burst_remaining(input logic [3:0] n);
    return {n, 1'b0} - REM_W'(1);
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running half-period prescaler; tick is high while the count sits at
// HALF_PERIOD-1, so every tick edge is also the wrap edge.
module led_tick_gen #(
  parameter int HALF_PERIOD = 13_500_000
) (
  input  logic Clock,
  input  logic Reset_n,
  output logic tick
);

  localparam int CW = (HALF_PERIOD > 2) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/led_blink_scheduler.sv
// Sequences NUM_CH LED channels (OFF/ON/BLINK/BURST) from one shared tick,
// configured through a valid/ready command port with optional tick-synchronous apply.
module led_blink_scheduler
  import led_ctrl_pkg::*;
#(
  parameter int HALF_PERIOD = 13_500_000,
  parameter int NUM_CH      = 4
) (
  input  logic                      Clock,
  input  logic                      Reset_n,
  input  logic                      Cmd_valid,
  output logic                      Cmd_ready,
  input  logic [$clog2(NUM_CH)-1:0] Cmd_ch,
  input  logic [1:0]                Cmd_mode,
  input  logic [3:0]                Cmd_count,
  input  logic                      Cmd_sync,
  output logic [NUM_CH-1:0]         LED_out,
  output logic [NUM_CH-1:0]         Active,
  output logic [NUM_CH-1:0]         Done
);

  localparam int CH_W = $clog2(NUM_CH);

  logic tick;

  led_tick_gen #(.HALF_PERIOD(HALF_PERIOD)) u_tick (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .tick    (tick)
  );

  cmd_state_t      state_q, state_d;
  logic [CH_W-1:0] pend_ch_q;
  logic [1:0]      pend_mode_q;
  logic [3:0]      pend_count_q;

  logic            apply, latch;
  logic [CH_W-1:0] app_ch;
  logic [1:0]      app_mode;
  logic [3:0]      app_count;

  always_comb begin
    state_d   = state_q;
    apply     = 1'b0;
    latch     = 1'b0;
    app_ch    = Cmd_ch;
    app_mode  = Cmd_mode;
    app_count = Cmd_count;
    case (state_q)
      IDLE: begin
        if (Cmd_valid) begin
          if (Cmd_sync) begin
            latch   = 1'b1;
            state_d = WAIT_TICK;
          end else begin
            apply = 1'b1;
          end
        end
      end
      WAIT_TICK: begin
        app_ch    = pend_ch_q;
        app_mode  = pend_mode_q;
        app_count = pend_count_q;
        if (tick) begin
          apply   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Cmd_ready = (state_q == IDLE);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pending payload is only meaningful in WAIT_TICK, which reset leaves.
  always_ff @(posedge Clock) begin
    if (latch) begin
      pend_ch_q    <= Cmd_ch;
      pend_mode_q  <= Cmd_mode;
      pend_count_q <= Cmd_count;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]       mode_q;
    logic             led_q;
    logic [REM_W-1:0] rem_q;
    logic             done_q;
    logic             hit;

    // An out-of-range Cmd_ch matches no channel, so the command is dropped.
    assign hit = apply && (app_ch == CH_W'(i));

    always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
        mode_q <= MODE_OFF;
        led_q  <= 1'b0;
        rem_q  <= '0;
        done_q <= 1'b0;
      end else begin
        done_q <= 1'b0;
        if (hit) begin
          rem_q <= '0;
          case (app_mode)
            MODE_ON: begin
              mode_q <= MODE_ON;
              led_q  <= 1'b1;
            end
            MODE_BLINK: begin
              mode_q <= MODE_BLINK;
              led_q  <= 1'b1;
            end
            MODE_BURST: begin
              if (app_count != 4'd0) begin
                mode_q <= MODE_BURST;
                led_q  <= 1'b1;
                rem_q  <= burst_remaining(app_count);
              end else begin
                mode_q <= MODE_OFF;
                led_q  <= 1'b0;
              end
            end
            default: begin
              mode_q <= MODE_OFF;
              led_q  <= 1'b0;
            end
          endcase
        end else if (tick) begin
          if (mode_q == MODE_BLINK) begin
            led_q <= ~led_q;
          end else if (mode_q == MODE_BURST) begin
            if (rem_q == REM_W'(1)) begin
              mode_q <= MODE_OFF;
              led_q  <= 1'b0;
              rem_q  <= '0;
              done_q <= 1'b1;
            end else if (rem_q != '0) begin
              led_q <= ~led_q;
              rem_q <= rem_q - REM_W'(1);
            end
          end
        end
      end
    end

    assign LED_out[i] = led_q;
    assign Active[i]  = (mode_q != MODE_OFF);
    assign Done[i]    = done_q;
  end

endmodule
